imem_boot_ctrl: RTL and testbench

- Controller and arbiter for the 64-word instruction memory.
- Owns the memory's write port. Loads a program from a byte-stream loader (UART/JTAG bridge) into the memory, then releases the CPU to fetch.
- Arbitrates the single address path between loader writes and CPU fetch reads.
- Substitutes NOP (add x0,x0,x0 = 32'h00000033) whenever the CPU must not see memory contents.

---
 rtl/imem_pkg.sv | 19 +
 rtl/byte_packer.sv | 48 ++++
 rtl/imem_boot_ctrl.sv | 176 +++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction memory boot controller
//
// Purpose: instruction memory geometry, the NOP substituted for blocked or
// faulting fetches, and the controller state encoding.
// Ports: none (package).

package imem_pkg;

  localparam int          DEPTH     = 64;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;  // add x0,x0,x0

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - four-byte little-endian word assembler
//
// Purpose: collects accepted loader bytes into a 32-bit word, first byte in
// [7:0], fourth byte in [31:24].
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr_i          drop any partial word and restart at byte 0
//   byte_valid_i   a byte is accepted this cycle
//   byte_data_i    the accepted byte
//   word_valid_o   this cycle's byte completes a word (combinational)
//   word_o         the completed word, valid with word_valid_o

module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_cnt_q;
  logic [23:0] buf_q;

  // The fourth byte is not stored; it is forwarded straight into the word so
  // the write can be issued on the very next cycle.
  assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
  assign word_o       = {byte_data_i, buf_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      buf_q      <= 24'd0;
    end else if (clr_i) begin
      byte_cnt_q <= 2'd0;
    end else if (byte_valid_i) begin
      case (byte_cnt_q)
        2'd0:    buf_q[7:0]   <= byte_data_i;
        2'd1:    buf_q[15:8]  <= byte_data_i;
        2'd2:    buf_q[23:16] <= byte_data_i;
        default: ;
      endcase
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory loader, fetch arbiter and NOP substitution
//
// Purpose: owns the instruction memory write port. In LOAD it packs loader
// bytes into words and writes them from address 0 upward; in RUN it hands
// the address path to the CPU. Outside RUN, or on a bad fetch address, the
// CPU sees NOP_INSTR.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   load_start, load_len       start/restart a load of load_len words (clamped to DEPTH)
//   byte_valid/data/ready      loader byte stream handshake
//   cpu_pc, cpu_instr          CPU fetch address and returned instruction
//   cpu_stall                  CPU must hold its PC
//   mem_addr/rdata/we/wdata    instruction memory port
//   load_done                  one-cycle pulse on load completion
//   fetch_fault                sticky bad-fetch flag, cleared by load_start

module imem_boot_ctrl #(
  parameter int          DEPTH     = imem_pkg::DEPTH,
  parameter bit          START_RUN = 1'b1,
  parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [$clog2(DEPTH):0]   load_len,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  input  logic [31:0]              cpu_pc,
  output logic [31:0]              cpu_instr,
  output logic                     cpu_stall,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  input  logic [31:0]              mem_rdata,
  output logic                     mem_we,
  output logic [31:0]              mem_wdata,
  output logic                     load_done,
  output logic                     fetch_fault
);

  import imem_pkg::state_e;
  import imem_pkg::ST_HOLD;
  import imem_pkg::ST_LOAD;
  import imem_pkg::ST_RUN;

  localparam int           AW          = $clog2(DEPTH);
  localparam logic [AW:0]  LEN_MAX     = (AW+1)'(DEPTH);
  localparam state_e       RESET_STATE = state_e'(START_RUN ? ST_RUN : ST_HOLD);

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic          byte_ready_q, byte_ready_d;
  logic          mem_we_q, mem_we_d;      // doubles as the pending-write flag
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          load_done_q, load_done_d;
  logic          fetch_fault_q, fetch_fault_d;

  logic [AW:0]   len_clamped;
  logic [AW:0]   word_cnt_inc;
  logic          fetch_ok;
  logic          byte_acc;
  logic          word_valid;
  logic [31:0]   word;

  assign len_clamped  = (load_len > LEN_MAX) ? LEN_MAX : load_len;
  assign word_cnt_inc = word_cnt_q + 1'b1;
  assign fetch_ok     = (cpu_pc[31:AW+2] == '0) && (cpu_pc[1:0] == 2'b00);

  // load_start takes priority: a byte offered in the same cycle is dropped.
  assign byte_acc = (state_q == ST_LOAD) && byte_valid && byte_ready_q && !load_start;

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (load_start),
    .byte_valid_i (byte_acc),
    .byte_data_i  (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    word_cnt_d    = word_cnt_q;
    byte_ready_d  = byte_ready_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    load_done_d   = 1'b0;
    fetch_fault_d = fetch_fault_q;

    if (load_start) begin
      // Start or restart: any pending write is dropped because mem_we_d
      // stays low, and the packer discards its partial word.
      len_d         = len_clamped;
      word_cnt_d    = '0;
      fetch_fault_d = 1'b0;
      if (len_clamped == '0) begin
        state_d      = ST_RUN;
        load_done_d  = 1'b1;
        byte_ready_d = 1'b0;
      end else begin
        state_d      = ST_LOAD;
        byte_ready_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (mem_we_q) begin
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == len_q) begin
              state_d      = ST_RUN;
              load_done_d  = 1'b1;
              byte_ready_d = 1'b0;
            end else begin
              byte_ready_d = 1'b1;
            end
          end else if (word_valid) begin
            mem_we_d     = 1'b1;
            mem_wdata_d  = word;
            byte_ready_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (!fetch_ok) fetch_fault_d = 1'b1;
        end
        ST_HOLD: ;
        default: begin
          state_d      = ST_HOLD;
          byte_ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_STATE;
      len_q         <= '0;
      word_cnt_q    <= '0;
      byte_ready_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 32'd0;
      load_done_q   <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      word_cnt_q    <= word_cnt_d;
      byte_ready_q  <= byte_ready_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      load_done_q   <= load_done_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Address arbitration: the CPU owns the path only in RUN.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      ST_RUN:  mem_addr = cpu_pc[AW+1:2];
      ST_LOAD: mem_addr = word_cnt_q[AW-1:0];
      default: mem_addr = '0;
    endcase
  end

  assign cpu_stall   = (state_q != ST_RUN);
  assign cpu_instr   = ((state_q == ST_RUN) && fetch_ok) ? mem_rdata : NOP_INSTR;
  assign byte_ready  = byte_ready_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign load_done   = load_done_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - scoreboard bench for imem_boot_ctrl

module tb_imem_boot_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        load_start;
  logic [6:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [31:0] cpu_pc;

  logic        byte_ready_a, cpu_stall_a, mem_we_a, load_done_a, fetch_fault_a;
  logic [31:0] cpu_instr_a, mem_rdata_a, mem_wdata_a;
  logic [5:0]  mem_addr_a;
  logic        byte_ready_b, cpu_stall_b, mem_we_b, load_done_b, fetch_fault_b;
  logic [31:0] cpu_instr_b, mem_rdata_b, mem_wdata_b;
  logic [5:0]  mem_addr_b;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] exp_words [64];
  logic [37:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int done_cnt  = 0;
  int wr_cnt    = 0;
  logic ready_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_boot_ctrl #(.START_RUN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr_a), .cpu_stall(cpu_stall_a),
    .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .mem_we(mem_we_a),
    .mem_wdata(mem_wdata_a), .load_done(load_done_a), .fetch_fault(fetch_fault_a)
  );

  imem_boot_ctrl #(.START_RUN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr_b), .cpu_stall(cpu_stall_b),
    .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .mem_we(mem_we_b),
    .mem_wdata(mem_wdata_b), .load_done(load_done_b), .fetch_fault(fetch_fault_b)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'hA000_0000 | 32'(i);
        mem_b[i] <= 32'hA000_0000 | 32'(i);
      end
    end else begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
  end
  assign mem_rdata_a = mem_a[mem_addr_a];
  assign mem_rdata_b = mem_b[mem_addr_b];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    logic [37:0] e;
    if (mem_we_a) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", {31'b0, mem_we_a}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {26'b0, mem_addr_a}, {26'b0, e[37:32]});
        check("wr_data", mem_wdata_a, e[31:0]);
      end
    end
    if (load_done_a) begin
      done_cnt++;
      done_cyc = cyc;
      check("stall_on_done", {31'b0, cpu_stall_a}, 32'd0);
    end
    if (ready_chk && cpu_stall_a)
      check("ready_vs_we", {31'b0, byte_ready_a}, {31'b0, !mem_we_a});
  end

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    do begin
      @(negedge clk);
      rdy = byte_ready_a;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) check("byte_ready_wait", {31'b0, rdy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    exp_words[addr] = w;
    exp_q.push_back({addr[5:0], w});
  endtask

  task automatic do_start(input logic [6:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    start_cyc  = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("load_done_count", 32'(done_cnt), 32'(target));
    check("ready_after_done", {31'b0, byte_ready_a}, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    logic [31:0] w;

    rst = 1'b1; preload = 1'b1; load_start = 1'b0; load_len = 7'd0;
    byte_valid = 1'b0; byte_data = 8'd0; cpu_pc = 32'h10;
    for (int i = 0; i < 64; i++) exp_words[i] = 32'hA000_0000 | 32'(i);
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset state
    check("rst_byte_ready", {31'b0, byte_ready_a}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we_a}, 32'd0);
    check("rst_mem_wdata", mem_wdata_a, 32'd0);
    check("rst_load_done", {31'b0, load_done_a}, 32'd0);
    check("rst_fetch_fault", {31'b0, fetch_fault_a}, 32'd0);
    check("b_hold_stall", {31'b0, cpu_stall_b}, 32'd1);
    check("b_hold_instr", cpu_instr_b, NOP);
    check("b_hold_addr", {26'b0, mem_addr_b}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // RUN fetches on the preloaded memory
    check("run_stall", {31'b0, cpu_stall_a}, 32'd0);
    check("run_addr", {26'b0, mem_addr_a}, 32'd4);
    check("run_instr", cpu_instr_a, 32'hA000_0004);
    cpu_pc = 32'h100;
    #1;
    check("oor_instr", cpu_instr_a, NOP);
    @(posedge clk);
    #1;
    check("oor_fault", {31'b0, fetch_fault_a}, 32'd1);
    cpu_pc = 32'h2;
    #1;
    check("misalign_instr", cpu_instr_a, NOP);
    cpu_pc = 32'h10;
    @(posedge clk);
    #1;
    check("fault_sticky", {31'b0, fetch_fault_a}, 32'd1);

    // Two-word load
    do_start(7'd2);
    check("load_fault_clr", {31'b0, fetch_fault_a}, 32'd0);
    check("load_stall", {31'b0, cpu_stall_a}, 32'd1);
    check("load_instr", cpu_instr_a, NOP);
    send_word(0, 32'h0010_0013);
    send_word(1, 32'h0020_0133);
    byte_valid = 1'b0;
    wait_done(1, 20);
    cpu_pc = 32'h0;
    #1;
    check("fetch_w0", cpu_instr_a, 32'h0010_0013);
    cpu_pc = 32'h4;
    #1;
    check("fetch_w1", cpu_instr_a, 32'h0020_0133);
    check("fetch_w1_addr", {26'b0, mem_addr_a}, 32'd1);

    // Sixteen words with byte_valid held high throughout
    ready_chk = 1'b1;
    do_start(7'd16);
    for (int i = 0; i < 16; i++) send_word(i, $urandom);
    byte_valid = 1'b0;
    wait_done(2, 100);
    ready_chk = 1'b0;
    check("load16_le80", {31'b0, (done_cyc - start_cyc) <= 80}, 32'd1);
    cpu_pc = 32'd20;
    #1;
    check("fetch16_w5", cpu_instr_a, exp_words[5]);

    // Restart after two bytes; the byte offered with load_start is dropped
    do_start(7'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_data = 8'hEE;
    do_start(7'd1);
    send_word(0, 32'h0BAD_F00D);
    byte_valid = 1'b0;
    wait_done(3, 20);
    cpu_pc = 32'h0;
    #1;
    check("restart_w0", cpu_instr_a, 32'h0BAD_F00D);

    // Zero-length load
    wr0 = wr_cnt;
    do_start(7'd0);
    check("len0_done", {31'b0, load_done_a}, 32'd1);
    check("len0_stall", {31'b0, cpu_stall_a}, 32'd0);
    wait_done(4, 5);
    check("len0_writes", 32'(wr_cnt - wr0), 32'd0);

    // Oversized length clamps to the full memory
    wr0 = wr_cnt;
    do_start(7'd100);
    for (int i = 0; i < 64; i++) send_word(i, $urandom);
    byte_valid = 1'b0;
    wait_done(5, 20);
    check("len100_writes", 32'(wr_cnt - wr0), 32'd64);
    check("len100_run", {31'b0, cpu_stall_a}, 32'd0);
    cpu_pc = 32'd252;
    #1;
    check("fetch_w63", cpu_instr_a, exp_words[63]);

    // Reset in the middle of a load
    do_start(7'd4);
    w = 32'h1234_5678;
    send_word(0, w);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    rst = 1'b1;
    #1;
    check("rst_a_run", {31'b0, cpu_stall_a}, 32'd0);
    check("rst_b_hold", {31'b0, cpu_stall_b}, 32'd1);
    check("rst_b_instr", cpu_instr_b, NOP);
    check("rst_a_ready", {31'b0, byte_ready_a}, 32'd0);
    check("rst_b_ready", {31'b0, byte_ready_b}, 32'd0);
    check("rst_a_we", {31'b0, mem_we_a}, 32'd0);
    check("rst_b_we", {31'b0, mem_we_b}, 32'd0);
    check("rst_keep_w0", mem_a[0], w);
    check("rst_keep_w1", mem_a[1], exp_words[1]);
    check("rst_keep_b_w0", mem_b[0], w);
    byte_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
